// File: rtl/regbank_seq_init.sv
// Parametrised register bank with an on-chip initialisation sequencer,
// same-cycle write-to-read bypass and an optional hardwired zero register.
module regbank_seq_init #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int INIT_MODE = 0,
    parameter int ZERO_REG  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic                     init_busy,
    output logic                     init_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   init_val;
    logic                user_wr;

    assign init_val  = (INIT_MODE == 1) ? DATA_W'(idx_q) : '0;
    // A write to register 0 is dropped entirely when it is hardwired to zero.
    assign user_wr   = we && !((ZERO_REG != 0) && (wa == '0));
    assign init_busy = (state_q == ST_INIT);
    assign init_done = done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = wa;
        wr_data = wd;
        case (state_q)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = init_val;
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                wr_en = user_wr;
                if (init_req) begin
                    state_d = ST_INIT;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // The array has no reset; the sequencer defines its contents.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        assign ra_k = ra[k*ADDR_W +: ADDR_W];
        assign rd[k*DATA_W +: DATA_W] =
            init_busy                        ? '0 :
            ((ZERO_REG != 0) && ra_k == '0)  ? '0 :
            (user_wr && wa == ra_k)          ? wd :
                                               mem_q[ra_k];
    end

endmodule
